// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data/valid, the transmitter answers with ready.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output data_in,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  data_in,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding buffer.
// Frames run back to back whenever a byte is pending at stop-bit end.
module uart_tx #(
  parameter int F    = 8000000,
  parameter int BAUD = 115200
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave up,
  output logic     tx,
  output logic     busy
);

  localparam int C = F / BAUD;
  localparam int W = (C > 2) ? $clog2(C) : 1;
  localparam logic [W-1:0] LAST = W'(C - 1);

  if (C < 2) begin : g_bad_rate
    $error("uart_tx: F/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t     state, state_n;
  logic [W-1:0] div, div_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] hold, hold_n;
  logic       full, full_n;
  logic       tx_n;
  logic       accept;
  logic       wrap;

  assign up.in_ready = !full;
  assign accept      = up.in_valid && !full;
  assign wrap        = (div == LAST);
  assign busy        = (state != IDLE) || full;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    shift_n = shift;
    hold_n  = hold;
    full_n  = full;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          shift_n = up.data_in;
        end
      end
      START: begin
        if (wrap) state_n = DATA;
      end
      DATA: begin
        if (wrap) begin
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (wrap) begin
          if (full) begin
            state_n = START;
            shift_n = hold;
            full_n  = 1'b0;
          end else if (accept) begin
            state_n = START;
            shift_n = up.data_in;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Mid-frame accepts park in the buffer; stop-end ones go straight out.
    if (accept && state != IDLE && !(state == STOP && wrap)) begin
      hold_n = up.data_in;
      full_n = 1'b1;
    end
  end

  always_comb begin
    div_n = div + W'(1);
    if (state == IDLE || wrap) div_n = '0;
  end

  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div   <= '0;
      idx   <= '0;
      shift <= '0;
      hold  <= '0;
      full  <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      div   <= div_n;
      idx   <= idx_n;
      shift <= shift_n;
      hold  <= hold_n;
      full  <= full_n;
      tx    <= tx_n;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter, the sending counterpart of the team's `uart_rx`, using the same `F`/`BAUD` parameterisation and 8N1 framing. It accepts bytes over a valid/ready handshake and buffers one byte behind the byte being shifted. It drives the serial line LSB first, with no idle gap between buffered frames. It sits between any byte producer (command FSM, FIFO) and the FPGA TX pin.

## Interface
- `F`, 8000000, system clock frequency in Hz
- `BAUD`, 115200, line bit rate; derived `C = F/BAUD` (integer division) clocks per bit; `C < 2` is an elaboration error
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `data_in`  input  8  byte to send, sampled on accept
- `in_valid`  input  1  producer has a byte on `data_in`
- `in_ready`  output  1  block can take a byte; accept = `in_valid && in_ready` at a rising edge
- `tx`  output  1  serial line, registered, idle high
- `busy`  output  1  high while a frame is on the line or the holding buffer is full

## Operation
- Reset values: `tx`=1, `in_ready`=1, `busy`=0. FSM=IDLE, holding buffer empty, divider=0, bit index=0.
- Reset mid-frame aborts the frame. `tx` is 1 after the reset edge. Shifter and buffer contents are discarded.
- FSM states and transitions:
  - IDLE → START on accept.
  - START → DATA after C cycles.
  - DATA → STOP after 8×C cycles, bit index 0..7, LSB first.
  - STOP → START if a byte is pending. STOP → IDLE otherwise.
- Line level per state: IDLE=1, START=0, DATA=`shift[0]`, STOP=1.
- Baud divider counts 0..C-1 in all non-IDLE states and wraps to 0 at C-1. A wrap ends the current bit. The divider is held at 0 in IDLE.
- Bit index increments on each divider wrap in DATA. It wraps 7→0 when leaving DATA.
- Holding buffer is one byte, with a `full` flag.
  - `in_ready = !full`.
  - Accept while IDLE: the byte loads the shifter directly and `full` stays 0.
  - Accept while not IDLE: the byte goes into the buffer and `full` is set.
  - At the STOP-end edge with `full`=1: the buffer moves to the shifter, `full` clears, and the next START begins on that same edge.
  - At the STOP-end edge with `full`=0 and a simultaneous accept: the byte goes straight to the shifter and START begins on that edge (no gap).
- `busy = (state != IDLE) || full`.
- `data_in` is ignored when there is no accept. `in_valid` held high with `in_ready` low stalls with no loss.

## Timing
- Accept at edge k from IDLE:
  - `tx` goes 0 after edge k, in the same edge (registered output).
  - Start bit spans edges k..k+C.
  - Data bit i spans k+(1+i)C..k+(2+i)C.
  - Stop bit spans k+9C..k+10C.
  - Frame is exactly 10C cycles.
- Back-to-back with buffer full: the next start bit begins at edge k+10C. `tx` is never high for less than C cycles between frames.
- `in_ready` is low from the edge after a buffer accept until the STOP-end edge. It is high again after that edge.
- `busy` falls after edge k+10C if nothing is pending.
- Jitter: every bit is exactly C cycles. Rate error from integer division is accepted (|F/C − BAUD|/BAUD).

## Test plan
- Reset/idle: hold `rst`=1 for 3 cycles, then release with `in_valid`=0 for 50 cycles → `tx`=1, `in_ready`=1, `busy`=0 throughout.
- Single frame (F=1000, BAUD=100, C=10): send 0xA5 → `tx` samples at mid-bit read 0,1,0,1,0,0,1,0,1,1. Each level lasts 10 cycles, total 100 cycles. `busy` is high exactly 100 cycles.
- Back-to-back: hold `in_valid`=1 with 0x00 then 0xFF → second start bit begins exactly 10C cycles after the first. `in_ready` drops after the second accept and rises at first-frame end. Line reads 0,00000000,1,0,11111111,1.
- Stall: with buffer full, hold `in_valid`=1 with `data_in`=0x3C → no accept until the STOP-end edge. 0x3C is transmitted intact as the third frame.
- Simultaneous STOP-end accept: buffer empty, assert `in_valid` exactly at the STOP-end edge with 0x81 → new start bit with zero idle cycles, bits 1,0,0,0,0,0,0,1.
- Reset mid-frame: assert `rst` during data bit 3 of 0x55 with a buffered 0xAA → `tx`=1 next cycle, `busy`=0, buffered byte never sent. A subsequent send of 0x12 is correct.
